// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-stage unit of the pipeline. It takes the execute-stage results and
// performs LDUR/STUR accesses to a multi-cycle data memory over a req/ack
// handshake. It also produces the CBZ branch-taken signal.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   memRead_M      load in the memory stage
//   memWrite_M     store in the memory stage (wins when both are set)
//   Branch_M       CBZ in the memory stage
//   zero_M         ALU zero flag
//   aluResult_M    effective address (N bits)
//   writeData_M    store data (N bits)
//   dm_req         memory request, held until ack or timeout
//   dm_we          1 = write, 0 = read; valid while dm_req
//   dm_addr        latched address; valid while dm_req
//   dm_wdata       latched store data; valid while dm_req
//   dm_rdata       read data, sampled when dm_ack is high
//   dm_ack         one-cycle completion strobe from memory
//   readData_M     registered load result, held until the next good load
//   stall_M        freeze PC and upstream registers
//   done_M         one-cycle pulse: access finished
//   misaligned_M   one-cycle pulse: unaligned address, access dropped
//   timeout_M      one-cycle pulse: access abandoned without ack
//   PCSrc_M        Branch_M & zero_M
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memRead_M,
   input  logic         memWrite_M,
   input  logic         Branch_M,
   input  logic         zero_M,
   input  logic [N-1:0] aluResult_M,
   input  logic [N-1:0] writeData_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic [N-1:0] dm_rdata,
   input  logic         dm_ack,
   output logic [N-1:0] readData_M,
   output logic         stall_M,
   output logic         done_M,
   output logic         misaligned_M,
   output logic         timeout_M,
   output logic         PCSrc_M
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          acc, al, start, limit;

   assign acc   = memRead_M | memWrite_M;
   assign al    = (aluResult_M[2:0] == 3'b000);
   assign start = (state == IDLE) && acc && al;
   // Last BUSY cycle the memory is given; an ack in this cycle still counts.
   assign limit = (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      stall_M   = 1'b0;
      case (state)
         IDLE: begin
            if (acc && al) begin
               stall_M   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall_M = 1'b1;
            if (dm_ack || limit) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         dm_we        <= 1'b0;
         dm_addr      <= '0;
         dm_wdata     <= '0;
         readData_M   <= '0;
         misaligned_M <= 1'b0;
         timeout_M    <= 1'b0;
      end else begin
         misaligned_M <= (state == IDLE) && acc && !al;
         timeout_M    <= (state == BUSY) && !dm_ack && limit;
         if (start) begin
            dm_addr  <= aluResult_M;
            dm_wdata <= writeData_M;
            dm_we    <= memWrite_M;
         end
         if (state == BUSY) begin
            if (dm_ack || limit) cnt <= '0;
            else                 cnt <= cnt + CW'(1);
            if (dm_ack && !dm_we) readData_M <= dm_rdata;
         end
      end
   end

   assign dm_req  = (state == BUSY);
   assign done_M  = (state == DONE);
   assign PCSrc_M = Branch_M & zero_M;

endmodule
